// File: rtl/fir_par2ser.sv
// Collects 3-sample output blocks from a 3-lane parallel FIR into a block FIFO
// and replays them one sample per valid/ready transfer, oldest sample first.
//
// Pop lane FSM
//   state | meaning
//   S0    | presenting y1 of the block at rd_ptr
//   S1    | presenting y2 of the block at rd_ptr
//   S2    | presenting y3; a transfer here frees the block
module fir_par2ser #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               y1,
  input  logic [W-1:0]               y2,
  input  logic [W-1:0]               y3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } lane_t;

  lane_t lane, lane_nxt;

  logic [W-1:0]  mem0 [DEPTH];
  logic [W-1:0]  mem1 [DEPTH];
  logic [W-1:0]  mem2 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, drop, xfer, pop_blk;

  // Both handshake outputs come from level alone, so no ready/valid loops.
  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);

  always_comb begin
    push     = in_valid && in_ready;
    drop     = in_valid && !in_ready;
    xfer     = out_valid && out_ready;
    lane_nxt = lane;
    pop_blk  = 1'b0;
    out_data = '0;
    if (xfer) begin
      case (lane)
        S0: lane_nxt = S1;
        S1: lane_nxt = S2;
        S2: begin
          lane_nxt = S0;
          pop_blk  = 1'b1;
        end
        default: lane_nxt = S0;
      endcase
    end
    if (out_valid) begin
      case (lane)
        S0:      out_data = mem0[rd_ptr];
        S1:      out_data = mem1[rd_ptr];
        S2:      out_data = mem2[rd_ptr];
        default: out_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane     <= S0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      lane <= lane_nxt;
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop_blk) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_blk})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is not reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr_ptr] <= y1;
      mem1[wr_ptr] <= y2;
      mem2[wr_ptr] <= y3;
    end
  end

endmodule

// File: tb/tb_fir_par2ser.sv
// Directed bench for fir_par2ser: reset, single block, stall, fill/overflow,
// full-with-pop drop, ramp with pointer wrap and mid-stream reset.
module tb_fir_par2ser;

  localparam int W = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  y1, y2, y3;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          overflow;
  logic [2:0]    level;

  int checks = 0;
  int errors = 0;

  fir_par2ser #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%08h) expected %0d (0x%08h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Advance past a rising edge; inputs and checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_blk(input int a, input int b, input int c);
    in_valid = 1'b1;
    y1 = a; y2 = b; y3 = c;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    y1 = '0; y2 = '0; y3 = '0;
    #1;

    // reset / idle
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_level",     32'(level),     0);
    chk("rst_overflow",  32'(overflow),  0);
    chk("rst_out_data",  out_data,       0);

    // single block, downstream always ready
    out_ready = 1'b1;
    set_blk(10, -20, 30);
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_s0", out_data, 10);
    tick();
    chk("single_s1", out_data, -20);
    tick();
    chk("single_s2", out_data, 30);
    tick();
    chk("single_done_valid", 32'(out_valid), 0);
    chk("single_done_level", 32'(level), 0);
    chk("single_done_data", out_data, 0);

    // backpressure: stall then 1,0,1,1
    out_ready = 1'b0;
    set_blk(1, 2, 3);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", out_data, 1);
      tick();
    end
    out_ready = 1'b1; chk("bp_p0", out_data, 1); tick();
    out_ready = 1'b0; chk("bp_p1", out_data, 2); tick();
    out_ready = 1'b1; chk("bp_p2", out_data, 2); tick();
    out_ready = 1'b1; chk("bp_p3", out_data, 3); tick();
    chk("bp_done_valid", 32'(out_valid), 0);

    // fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_blk(100 * i + 1, 100 * i + 2, 100 * i + 3);
      chk("fill_in_ready", 32'(in_ready), (i < 4) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    chk("fill_level", 32'(level), 4);
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_in_ready_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk("drain_data", out_data, 100 * i + j + 1);
        tick();
      end
    end
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_overflow_sticky", 32'(overflow), 1);

    // full with simultaneous block-completing pop
    do_reset();
    chk("fp_overflow_clear", 32'(overflow), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_blk(50 + 10 * i, 51 + 10 * i, 52 + 10 * i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("fp_lane_s2_data", out_data, 52);
    set_blk(999, 998, 997);
    chk("fp_in_ready_low", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    chk("fp_overflow", 32'(overflow), 1);
    chk("fp_level", 32'(level), 3);
    chk("fp_in_ready_next", 32'(in_ready), 1);
    for (int i = 1; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk("fp_drain", out_data, 50 + 10 * i + j);
        tick();
      end
    end
    chk("fp_drain_empty", 32'(out_valid), 0);

    // ramp at 1 block per 3 cycles, wraps pointers twice
    do_reset();
    out_ready = 1'b1;
    set_blk(0, 1, 2);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk("ramp_data", out_data, 3 * k + j);
        chk("ramp_level", 32'(level), 1);
        if (j == 2 && k < 9) set_blk(3 * k + 3, 3 * k + 4, 3 * k + 5);
        tick();
        in_valid = 1'b0;
      end
    end
    chk("ramp_empty", 32'(out_valid), 0);

    // reset while lane is at S1
    set_blk(70, 71, 72);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_s1_data", out_data, 71);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_data", out_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_par2ser.md
Name: fir_par2ser

Overview:
- Output-side companion to the 3-lane parallel FIR variants (L=3, with or without pipelining).
- Accepts one 3-sample output block per cycle (y1, y2, y3 in time order), buffers whole blocks in a small FIFO, and emits them as a serial one-sample-per-transfer stream with valid/ready.
- Restores the single-rate sample order for downstream serial consumers and checkers.
- Provides backpressure where the upstream can honour it, and a sticky overflow flag where it cannot.

Parameters:
- W, 32, sample width in bits (signed two's complement).
- DEPTH, 4, FIFO depth in 3-sample blocks. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a block is presented on y1/y2/y3.
- in_ready  out  1  FIFO can accept a block this cycle.
- y1  in  W  block sample 0 (oldest).
- y2  in  W  block sample 1.
- y3  in  W  block sample 2 (newest).
- out_valid  out  1  out_data holds a valid sample.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  W  serial sample.
- overflow  out  1  sticky flag: a block was dropped.
- level  out  $clog2(DEPTH)+1  number of stored blocks, 0..DEPTH.

Behaviour:
- Reset, applied when rst is high at a clk edge:
  - wr_ptr, rd_ptr, lane, level all 0.
  - overflow 0.
  - Consequently out_valid 0 and in_ready 1.
  - Reset mid-stream discards all buffered blocks and any partially emitted block.
  - Storage contents need not be cleared.
- in_ready = (level != DEPTH).
  - Depends on registered state only; no combinational path from out_ready.
- Push: when in_valid && in_ready, store {y1,y2,y3} at wr_ptr and increment wr_ptr modulo DEPTH.
- Drop: when in_valid && !in_ready, the block is discarded and overflow is set to 1 on the next edge. overflow stays 1 until rst.
- Output side:
  - out_valid = (level != 0).
  - out_data = lane-th sample of the block at rd_ptr, with lane 0 giving y1, lane 1 y2, lane 2 y3.
  - out_data = 0 when out_valid is 0.
- Pop FSM, lane states S0 -> S1 -> S2:
  - On out_valid && out_ready, lane advances.
  - In S2 the transfer returns lane to S0, increments rd_ptr modulo DEPTH, and frees the block.
  - With no transfer, lane and out_data hold; the sample is stable while out_valid && !out_ready.
- Level update:
  - +1 on push only.
  - -1 on block-completing pop only.
  - Unchanged when both occur in the same cycle.
- Full with simultaneous pop completion: in_ready is still 0 that cycle, so the incoming block is dropped and overflow is set. in_ready rises the next cycle. No same-cycle pass-through.
- Empty with simultaneous push: out_valid rises the cycle after the push.
  - Latency from push to the first sample on out_data is 1 cycle.
- Pointers wrap from DEPTH-1 to 0. level distinguishes full from empty.
- Throughput: at most 1 sample per cycle out.
  - Sustained input must average no more than 1 block per 3 cycles with out_ready held high.
  - Bursts up to DEPTH blocks are absorbed.
- Arithmetic: samples pass through bit-exact, with no sign extension or truncation.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst 3 cycles, then release with in_valid=0.
  - Response: out_valid=0, in_ready=1, level=0, overflow=0, out_data=0.
- Single block:
  - Stimulus: push y1=10, y2=-20, y3=30 with out_ready=1.
  - Response: out_data sequence 10, -20, 30 on the 3 cycles after the push, then out_valid=0 and level returns to 0.
- Backpressure:
  - Stimulus: push y1=1, y2=2, y3=3. Hold out_ready=0 for 5 cycles, then pulse out_ready 1,0,1,1.
  - Response: out_data holds 1 while stalled. Outputs in order 1, 2, 3 with no duplicate or skip.
- Fill and overflow:
  - Stimulus: out_ready=0, push 5 consecutive blocks with DEPTH=4.
  - Response: in_ready=0 after the 4th push, level=4, 5th block dropped, overflow=1.
  - Then drain with out_ready=1: 12 samples from blocks 1-4 only. overflow stays 1.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, lane at S2 with out_ready=1, and in_valid=1 in the same cycle.
  - Response: block dropped, overflow=1, level=3 next cycle, in_ready=1 next cycle.
- Wrap and reset mid-stream:
  - Stimulus: stream ramp blocks (3k, 3k+1, 3k+2) for k = 0..9 at 1 block per 3 cycles with out_ready=1.
  - Response: out_data is the contiguous ramp 0..29 with pointers wrapping twice.
  - Then assert rst at lane S1: next cycle out_valid=0, level=0, overflow=0.
